// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its winner-select block.
// Also holds the small helpers used to pick the winning port's request fields.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_AUX = 1'b1;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Port index of a one-hot grant vector; bit 1 set means the aux port won.
  function automatic logic port_of(input logic [1:0] onehot);
    return onehot[1];
  endfunction

endpackage

// File: rtl/arb2_select.sv
// Two-way winner select producing a one-hot grant from two requests.
// Round-robin favours the port that did not win last; fixed priority favours port 0 unless starve is set.
module arb2_select
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic       prio_mode,
  input  logic       starve,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      if (prio_mode)
        gnt = starve ? 2'b10 : 2'b01;
      else
        gnt = (last == P_CPU) ? 2'b10 : 2'b01;
    end else begin
      gnt = {req1, req0};
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core (port 0) and an auxiliary master (port 1).
// Grants are combinational; read completion is tracked with a down-counter so a new access can overlap rvalid.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [2:0]    memop0,
  input  logic [2:0]    memop1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_datain,
  output logic [2:0]    mem_memop,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_dataout,
  output logic          busy
);

  localparam logic [2:0] RD_LAT_C   = 3'(RD_LAT);
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic       FIXED_C    = (PRIO_MODE == PRIO_FIXED);

  arb_state_e    state;
  logic [2:0]    rcnt;
  logic          rport;
  logic          last;
  logic [7:0]    wcnt;

  logic [AW-1:0] addr_p1;
  logic [DW-1:0] wdata_p1;
  logic [2:0]    memop_p1;

  logic          issue_ok;
  logic          cmpl;
  logic          starve;
  logic [1:0]    sel;
  logic          issue;
  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [2:0]    win_memop;

  // The completion cycle of a read is also an issue slot, so reads can stream back to back.
  assign cmpl     = !reset && (state == RD_WAIT) && (rcnt == 3'd1);
  assign issue_ok = !reset && ((state == IDLE) || (rcnt == 3'd1));
  assign starve   = (wcnt == MAX_WAIT_C);

  arb2_select u_sel (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .prio_mode (FIXED_C),
    .starve    (starve),
    .gnt       (sel)
  );

  assign gnt0      = issue_ok && sel[0];
  assign gnt1      = issue_ok && sel[1];
  assign issue     = gnt0 || gnt1;
  assign win       = port_of({gnt1, gnt0});
  assign win_we    = win ? we1 : we0;
  assign win_addr  = win ? addr1 : addr0;
  assign win_wdata = win ? wdata1 : wdata0;
  assign win_memop = win ? memop1 : memop0;

  assign mem_we     = issue && win_we;
  assign mem_re     = issue && !win_we;
  assign mem_addr   = issue ? win_addr : addr_p1;
  assign mem_datain = issue ? win_wdata : wdata_p1;
  assign mem_memop  = issue ? win_memop : memop_p1;

  assign rvalid0 = cmpl && (rport == P_CPU);
  assign rvalid1 = cmpl && (rport == P_AUX);
  assign rdata   = mem_dataout;
  assign busy    = !reset && (state == RD_WAIT);

  // Stage p1: hold the last issued request fields on the memory bus between grants.
  always_ff @(posedge clock) begin
    if (issue) begin
      addr_p1  <= win_addr;
      wdata_p1 <= win_wdata;
      memop_p1 <= win_memop;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rcnt  <= 3'd0;
      rport <= P_CPU;
      last  <= P_AUX;
      wcnt  <= 8'd0;
    end else begin
      if (issue)
        last <= win;

      if (issue && !win_we) begin
        state <= RD_WAIT;
        rcnt  <= RD_LAT_C;
        rport <= win;
      end else if (state == RD_WAIT) begin
        if (rcnt == 3'd1) begin
          state <= IDLE;
          rcnt  <= 3'd0;
        end else begin
          rcnt <= rcnt - 3'd1;
        end
      end

      // Starvation guard only matters under fixed priority; it stays at zero in round-robin.
      if (FIXED_C) begin
        if (!req1 || gnt1)
          wcnt <= 8'd0;
        else if (issue_ok && (wcnt != MAX_WAIT_C))
          wcnt <= wcnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (addr/datain/dataout/memop/we) between two masters: port 0 is the rv32 core's data side, port 1 is a secondary master such as a debug loader or DMA.
- Sits between the masters and dmem in the CPU top level.
- Provides a req/gnt handshake, read-latency tracking and selectable arbitration (round-robin, or fixed priority with a starvation guard).

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, cycles from mem_re to valid mem_dataout; legal range 1..7.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to port 0 with starvation guard.
- MAX_WAIT, 8, in PRIO_MODE=1: waiting cycles after which port 1 is forced to win; legal range 1..255.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  access request; must be held with its attributes until gnt.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  AW  byte address.
- wdata0 / wdata1  in  DW  write data.
- memop0 / memop1  in  3  access size/sign code, forwarded unchanged.
- gnt0 / gnt1  out  1  combinational; access issued to memory this cycle.
- rvalid0 / rvalid1  out  1  one-cycle pulse, read data valid.
- rdata  out  DW  equals mem_dataout; meaningful only while an rvalid is high.
- mem_addr  out  AW  address to memory.
- mem_datain  out  DW  write data to memory.
- mem_memop  out  3  size/sign code to memory.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_dataout  in  DW  read data from memory.
- busy  out  1  read outstanding.

Behaviour:
- Reset values (applied while reset is high):
  - gnt0/1, rvalid0/1, mem_we, mem_re and busy are 0.
  - The wait counter is 0.
  - The round-robin pointer last = 1, so port 0 wins the first tie.
  - Any outstanding read is dropped; no rvalid is ever emitted for a read issued before reset.
- States: IDLE and RD_WAIT, with a down-counter rcnt of 3 bits.
- Issue is allowed when the state is IDLE, or when the state is RD_WAIT and rcnt == 1 (the completion cycle). This lets a new access issue in the same cycle as the previous rvalid.
- In an issue-allowed cycle with any req high, the winner is selected combinationally and, in the same cycle:
  - gntW = 1.
  - mem_addr, mem_datain and mem_memop are taken from port W.
  - mem_we = weW; mem_re = !weW.
  - At most one gnt is high per cycle.
- Writes complete in the grant cycle; no response is returned. After a write the state is IDLE.
- Read granted at cycle T:
  - State becomes RD_WAIT and rcnt = RD_LAT.
  - The arbiter records the requesting port.
  - At cycle T+RD_LAT, rvalid for that port = 1 and rdata = mem_dataout.
  - busy is 1 from T+1 through T+RD_LAT.
- rcnt decrements each cycle in RD_WAIT. At rcnt == 1 the state goes to IDLE, unless a new read issues in that cycle, in which case the state stays RD_WAIT and rcnt reloads to RD_LAT.
- Round-robin (PRIO_MODE=0):
  - A single requester always wins.
  - If both request, the port != last wins.
  - last updates to W on every grant.
- Fixed priority (PRIO_MODE=1):
  - Port 0 wins ties.
  - wcnt increments (saturating at MAX_WAIT) in each issue-allowed cycle where req1 && !gnt1.
  - When wcnt == MAX_WAIT, port 1 wins the next tie.
  - wcnt clears on gnt1 or when req1 is low.
- When memory is not issue-allowed, gnt is 0 and mem_we/mem_re are 0. mem_addr, mem_datain and mem_memop hold their last values; they are don't-care.
- A requester dropping req without a gnt is legal; no access occurs.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE, RD_WAIT);
  - port index constants P_CPU = 0, P_AUX = 1;
  - PRIO_RR = 0, PRIO_FIXED = 1.
- Sub-module arb2_select: 2-way winner select from req0, req1, last, prio_mode and starve; outputs a one-hot grant. It is reused by the future MMIO bus arbiter.

Test Plan:
- Reset, then req0 read of addr 0x10 at cycle 5 with RD_LAT=1 and memory returning 0xDEADBEEF:
  - gnt0 = 1 and mem_re = 1 at cycle 5.
  - rvalid0 = 1 and rdata = 0xDEADBEEF at cycle 6.
  - busy = 1 at cycle 6 only.
- req0 and req1 held continuously, all reads, PRIO_MODE=0: grants alternate 0,1,0,1 on consecutive cycles; each rvalid arrives exactly one cycle after its gnt on the matching port.
- PRIO_MODE=1, MAX_WAIT=3, req0 and req1 both writes held high: gnt0 on 3 issue cycles, then gnt1 on the 4th, then gnt0 resumes; wcnt = 0 after gnt1.
- RD_LAT=3, back-to-back req1 reads:
  - gnt1 at T, T+3, T+6.
  - rvalid1 at T+3, T+6, T+9.
  - No gnt at T+1 or T+2, even with req0 high.
- Read granted at T with RD_LAT=3, reset asserted at T+1 for 1 cycle: no rvalid at T+3; state is IDLE at T+2; a req0 at T+2 gets gnt0 immediately.
- Write from port 1 (addr 0x20, data 0x12345678, memop 3'b010) coincident with rvalid0 completion: mem_we = 1 with those values in that same cycle; no rvalid1 follows.
